time_set_ctrl: RTL

User time-setting controller for the digital clock's hour and minute counters. Converts two raw push-buttons (mode, increment) into a set-mode state machine. The state machine captures the running time, lets the user step the hour (0–23) and then the minute (0–59), and commits both values with a single-cycle load. Sits between the front-panel buttons and the hour/minute counter blocks. It gates their advance while setting and blinks the field being edited via the counters' databus enables.

---
 rtl/clock_pkg.sv | 35 +++
 rtl/btn_pulse.sv | 56 +++++
 rtl/time_set_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock's time-setting path.
// Holds the set-mode state encoding, field widths/limits and small field helpers.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_e;

  // A counter value that is out of range is treated as midnight / top of hour.
  function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] h);
    return (h > HOUR_MAX) ? '0 : h;
  endfunction

  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
    return (m > MIN_MAX) ? '0 : m;
  endfunction

  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
    return (h >= HOUR_MAX) ? '0 : h + HOUR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
    return (m >= MIN_MAX) ? '0 : m + MIN_W'(1);
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and a registered
// single-cycle pulse on each accepted 0->1 change.
module btn_pulse #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // The counter tracks how many consecutive synchronized samples disagree with
  // the accepted level; any agreeing sample restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: captures the running time, steps hour then
// minute under button control, and commits both to the counters with one load cycle.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int BLINK_DIV  = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [HOUR_W-1:0] hour_in,
  input  logic [MIN_W-1:0]  min_in,
  output logic              hour_load,
  output logic [HOUR_W-1:0] hour_data,
  output logic              min_load,
  output logic [MIN_W-1:0]  min_data,
  output logic              run_en,
  output logic              hour_en,
  output logic              min_en,
  output logic [1:0]        state
);

  localparam int BLINK_W = $clog2(2 * BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_OFF  = BLINK_W'(BLINK_DIV);

  logic mode_p, inc_p;

  state_e             state_q, state_d;
  logic [HOUR_W-1:0]  edit_hour_q, edit_hour_d;
  logic [MIN_W-1:0]   edit_min_q, edit_min_d;
  logic [BLINK_W-1:0] blink_q, blink_d;

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_mode_btn (
    .clk     (clk),
    .clear   (clear),
    .btn_i   (btn_mode),
    .pulse_o (mode_p)
  );

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_inc_btn (
    .clk     (clk),
    .clear   (clear),
    .btn_i   (btn_inc),
    .pulse_o (inc_p)
  );

  // Mode is tested before increment in each set state, so a coincident
  // increment is discarded.
  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    case (state_q)
      RUN: begin
        if (mode_p) begin
          state_d     = SET_HOUR;
          edit_hour_d = clamp_hour(hour_in);
          edit_min_d  = clamp_min(min_in);
        end
      end
      SET_HOUR: begin
        if (mode_p)     state_d     = SET_MIN;
        else if (inc_p) edit_hour_d = inc_hour(edit_hour_q);
      end
      SET_MIN: begin
        if (mode_p)     state_d    = COMMIT;
        else if (inc_p) edit_min_d = inc_min(edit_min_q);
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Blink phase restarts on every state entry so the edited field always opens lit.
  always_comb begin
    if (state_d != state_q)        blink_d = '0;
    else if (blink_q == BLINK_LAST) blink_d = '0;
    else                            blink_d = blink_q + BLINK_W'(1);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= RUN;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      blink_q     <= blink_d;
    end
  end

  assign state     = state_q;
  assign hour_load = (state_q == COMMIT);
  assign min_load  = (state_q == COMMIT);
  assign hour_data = edit_hour_q;
  assign min_data  = edit_min_q;
  assign run_en    = (state_q == RUN);
  assign hour_en   = !((state_q == SET_HOUR) && (blink_q >= BLINK_OFF));
  assign min_en    = !((state_q == SET_MIN)  && (blink_q >= BLINK_OFF));

endmodule
